// File: rtl/spi_master_tx.sv
// spi_master_tx -- byte-oriented SPI initiator, mode 0 (CPOL=0, CPHA=0),
// MSB first, MOSI only.
//
// Each accepted byte is framed as follows:
//   LOW/HIGH pairs: 8 bits, each half-period lasting CLK_DIV cycles.
//   TRAIL: cs stays low for one more half-period after the last fall.
//   GAP: cs is high for CLK_DIV cycles before the block returns to IDLE.
// A byte is therefore 17*CLK_DIV cycles from accept to the end of TRAIL.
//
// Optional feature: define SPI_MASTER_BURST_EN to accept the next byte on
// the last TRAIL cycle. The new byte then continues the same cs frame and
// GAP is skipped.
//
// Parameters
//   CLK_DIV   clk cycles per sck half-period (2..255), default 8
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   in_data   byte to send, sampled only on the accept edge
//   in_valid  a byte is available
//   in_ready  block can accept (accept = in_valid & in_ready at clk rise)
//   cs        chip select, active low, registered
//   sck       serial clock, idles low, registered
//   mosi      serial data, registered
//   busy      high in every state except IDLE
//   done      one-cycle pulse on the last TRAIL cycle of each byte
`timescale 1ns/1ps
`default_nettype none

module spi_master_tx #(
    parameter int CLK_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cs,
    output logic       sck,
    output logic       mosi,
    output logic       busy,
    output logic       done
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    // One cycle before the last: registered outputs that must be visible
    // on the last cycle of a phase are set here.
    localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_TRAIL,
        S_GAP
    } state_t;

    state_t          state_reg;
    logic [7:0]      shift_reg;
    logic [2:0]      bit_cnt_reg;
    logic [DW-1:0]   div_reg;
    logic            in_ready_reg;
    logic            cs_reg;
    logic            sck_reg;
    logic            mosi_reg;
    logic            busy_reg;
    logic            done_reg;

    logic            div_last;
    logic            accept;

    assign div_last = (div_reg == DIV_LAST);
    assign accept   = in_valid && in_ready_reg;

    assign in_ready = in_ready_reg;
    assign cs       = cs_reg;
    assign sck      = sck_reg;
    assign mosi     = mosi_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            shift_reg    <= 8'h00;
            bit_cnt_reg  <= 3'd0;
            div_reg      <= '0;
            in_ready_reg <= 1'b0;
            cs_reg       <= 1'b1;
            sck_reg      <= 1'b0;
            mosi_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    div_reg      <= '0;
                    cs_reg       <= 1'b1;
                    sck_reg      <= 1'b0;
                    mosi_reg     <= 1'b0;
                    busy_reg     <= 1'b0;
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        // MSB goes out together with the cs fall.
                        shift_reg    <= in_data;
                        bit_cnt_reg  <= 3'd0;
                        cs_reg       <= 1'b0;
                        mosi_reg     <= in_data[7];
                        busy_reg     <= 1'b1;
                        in_ready_reg <= 1'b0;
                        state_reg    <= S_LOW;
                    end
                end

                S_LOW: begin
                    if (div_last) begin
                        div_reg   <= '0;
                        sck_reg   <= 1'b1;
                        state_reg <= S_HIGH;
                    end else begin
                        div_reg <= div_reg + DW'(1);
                    end
                end

                S_HIGH: begin
                    if (div_last) begin
                        div_reg <= '0;
                        sck_reg <= 1'b0;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= S_TRAIL;
                        end else begin
                            // MOSI only changes on the sck fall, giving a
                            // full half-period of setup and hold.
                            shift_reg   <= {shift_reg[6:0], 1'b0};
                            mosi_reg    <= shift_reg[6];
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            state_reg   <= S_LOW;
                        end
                    end else begin
                        div_reg <= div_reg + DW'(1);
                    end
                end

                S_TRAIL: begin
                    if (div_last) begin
                        div_reg      <= '0;
                        in_ready_reg <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
                        if (accept) begin
                            // Next byte continues the current cs frame.
                            shift_reg   <= in_data;
                            bit_cnt_reg <= 3'd0;
                            mosi_reg    <= in_data[7];
                            state_reg   <= S_LOW;
                        end else begin
                            cs_reg    <= 1'b1;
                            mosi_reg  <= 1'b0;
                            state_reg <= S_GAP;
                        end
`else
                        cs_reg    <= 1'b1;
                        mosi_reg  <= 1'b0;
                        state_reg <= S_GAP;
`endif
                    end else begin
                        div_reg <= div_reg + DW'(1);
                        if (div_reg == DIV_PRE) begin
                            done_reg <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
                            in_ready_reg <= 1'b1;
`endif
                        end
                    end
                end

                S_GAP: begin
                    if (div_last) begin
                        div_reg      <= '0;
                        busy_reg     <= 1'b0;
                        in_ready_reg <= 1'b1;
                        state_reg    <= S_IDLE;
                    end else begin
                        div_reg <= div_reg + DW'(1);
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_tx.sv
// Testbench for spi_master_tx. Three instances run side by side at
// CLK_DIV = 4, 2 and 255. Stimulus pushes each accepted byte into a
// per-instance expected queue; a negedge monitor rebuilds bytes from
// mosi at sck rises and checks them on every done pulse, together with
// accept-to-done latency, sck half-periods, cs frame length and the
// number of sck rises per frame.
`timescale 1ns/1ps

module tb_spi_master_tx;

    localparam int N = 3;

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 2 : 255;
    endfunction

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_valid;
    logic [7:0]     in_data [N];
    wire  [N-1:0]   in_ready;
    wire  [N-1:0]   cs;
    wire  [N-1:0]   sck;
    wire  [N-1:0]   mosi;
    wire  [N-1:0]   busy;
    wire  [N-1:0]   done;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            spi_master_tx #(.CLK_DIV(div_of(gi))) u_dut (
                .clk      (clk),
                .reset    (reset),
                .in_data  (in_data[gi]),
                .in_valid (in_valid[gi]),
                .in_ready (in_ready[gi]),
                .cs       (cs[gi]),
                .sck      (sck[gi]),
                .mosi     (mosi[gi]),
                .busy     (busy[gi]),
                .done     (done[gi])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected bytes and the monitor's accept timestamps.
    logic [7:0] exp_q [N][$];
    int         acc_q [N][$];

    // Monitor state.
    int         cyc = 0;
    logic       prev_sck [N];
    logic       prev_cs  [N];
    logic [7:0] rx_byte  [N];
    int         rx_cnt   [N];
    int         phase_len[N];
    logic       first_rise[N];
    int         low_cnt  [N];
    int         high_cnt [N];
    int         frame_dones[N];
    int         frame_rises[N];
    int         last_gap [N];
    int         done_total[N];

    initial begin
        for (int i = 0; i < N; i++) begin
            done_total[i] = 0;
            last_gap[i]   = 0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                rx_cnt[i]      = 0;
                rx_byte[i]     = 8'h00;
                phase_len[i]   = 0;
                low_cnt[i]     = 0;
                high_cnt[i]    = 0;
                frame_dones[i] = 0;
                frame_rises[i] = 0;
                first_rise[i]  = 1'b0;
                acc_q[i].delete();
                prev_sck[i]    = sck[i];
                prev_cs[i]     = cs[i];
            end else begin
                // cs frame tracking
                if (!cs[i]) begin
                    if (prev_cs[i]) begin
                        last_gap[i]    = high_cnt[i];
                        low_cnt[i]     = 1;
                        phase_len[i]   = 0;
                        frame_dones[i] = 0;
                        frame_rises[i] = 0;
                        first_rise[i]  = 1'b1;
                    end else begin
                        low_cnt[i]++;
                    end
                end else begin
                    if (!prev_cs[i]) begin
                        high_cnt[i] = 1;
                        check($sformatf("cs_low_len[%0d]", i), low_cnt[i], 17 * div_of(i) * frame_dones[i]);
                        check($sformatf("sck_rises[%0d]", i), frame_rises[i], 8 * frame_dones[i]);
                    end else begin
                        high_cnt[i]++;
                    end
                end

                // sck edges
                if (sck[i] && !prev_sck[i]) begin
                    if (first_rise[i])
                        check($sformatf("sck_first_low[%0d]", i), phase_len[i], div_of(i));
                    first_rise[i]  = 1'b0;
                    rx_byte[i]     = {rx_byte[i][6:0], mosi[i]};
                    rx_cnt[i]++;
                    frame_rises[i]++;
                    phase_len[i]   = 0;
                end else if (!sck[i] && prev_sck[i]) begin
                    check($sformatf("sck_high_len[%0d]", i), phase_len[i], div_of(i));
                    phase_len[i] = 0;
                end

                // byte completion
                if (done[i]) begin
                    done_total[i]++;
                    frame_dones[i]++;
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("sb_unexpected_done[%0d]", i), 1, 0);
                    end else begin
                        check($sformatf("data[%0d]", i), rx_byte[i], exp_q[i].pop_front());
                        check($sformatf("bits[%0d]", i), rx_cnt[i], 8);
                    end
                    if (acc_q[i].size() == 0)
                        check($sformatf("done_no_accept[%0d]", i), 1, 0);
                    else
                        check($sformatf("done_latency[%0d]", i), cyc - acc_q[i].pop_front(), 17 * div_of(i));
                    rx_cnt[i] = 0;
                end

                // Handshake seen here completes on the next rising edge.
                if (in_valid[i] && in_ready[i])
                    acc_q[i].push_back(cyc);

                phase_len[i]++;
                prev_sck[i] = sck[i];
                prev_cs[i]  = cs[i];
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input int i, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_data[i]  = b;
        in_valid[i] = 1'b1;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (in_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            exp_q[i].push_back(b);
            @(posedge clk);
            #1;
        end else begin
            check($sformatf("accept_timeout[%0d]", i), 0, 1);
        end
        in_valid[i] = 1'b0;
        $display("tx inst=%0d byte=%02h accepted=%0d t=%0t", i, b, ok, $time);
    endtask

    task automatic wait_idle(input int i);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (!busy[i] && in_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        check($sformatf("idle_reached[%0d]", i), ok, 1);
        @(posedge clk);
        #1;
    endtask

    int dt;

    initial begin
        reset = 1'b1;
        in_valid = '0;
        for (int i = 0; i < N; i++) in_data[i] = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_cs[%0d]", i), cs[i], 1);
            check($sformatf("rst_sck[%0d]", i), sck[i], 0);
            check($sformatf("rst_mosi[%0d]", i), mosi[i], 0);
            check($sformatf("rst_in_ready[%0d]", i), in_ready[i], 0);
            check($sformatf("rst_busy[%0d]", i), busy[i], 0);
            check($sformatf("rst_done[%0d]", i), done[i], 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("idle_in_ready[%0d]", i), in_ready[i], 1);
            check($sformatf("idle_busy[%0d]", i), busy[i], 0);
        end

        // Single byte, CLK_DIV=4.
        send(0, 8'hA5);
        wait_idle(0);
        check("single_done_count", done_total[0], 1);

        // Handshake hold-off: in_valid/in_data toggle while busy are ignored.
        send(0, 8'h5A);
        check("holdoff_in_ready", in_ready[0], 0);
        check("holdoff_busy", busy[0], 1);
        in_valid[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data[0] = 8'h11 * k[7:0];
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        wait_idle(0);
        dt = done_total[0];
        check("holdoff_done_count", dt, 2);
        repeat (50) @(posedge clk);
        #1;
        check("quiet_cs", cs[0], 1);
        check("quiet_sck", sck[0], 0);
        check("quiet_no_done", done_total[0], dt);

        // Back-to-back with in_valid held across the bytes.
        send(0, 8'h3C);
        send(0, 8'hC3);
        wait_idle(0);
`ifdef SPI_MASTER_BURST_EN
        check("burst_frame_dones", frame_dones[0], 2);
`else
        check("nob_frame_dones", frame_dones[0], 1);
        check("nob_cs_gap", last_gap[0], 5);
`endif
        check("b2b_done_count", done_total[0], 4);

        // Reset mid-byte, HIGH phase of bit 3 (0x1F sends 0,0,0,1,...).
        send(0, 8'h1F);
        repeat (29) @(posedge clk);
        #2;
        check("pre_reset_sck", sck[0], 1);
        check("pre_reset_mosi", mosi[0], 1);
        dt = done_total[0];
        reset = 1'b1;
        exp_q[0].delete();
        #1;
        check("midrst_cs", cs[0], 1);
        check("midrst_sck", sck[0], 0);
        check("midrst_mosi", mosi[0], 0);
        check("midrst_done", done[0], 0);
        check("midrst_busy", busy[0], 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_done", done_total[0], dt);
        send(0, 8'h81);
        wait_idle(0);
        check("post_rst_done_count", done_total[0], dt + 1);

        // Divider extremes, running concurrently.
        send(1, 8'hFF);
        send(2, 8'h00);
        wait_idle(1);
        wait_idle(2);
        check("div2_done_count", done_total[1], 1);
        check("div255_done_count", done_total[2], 1);

        for (int i = 0; i < N; i++)
            check($sformatf("sb_empty[%0d]", i), exp_q[i].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
